ahb_slave_mux: RTL and testbench



---
 rtl/ahb_slave_mux.sv | 117 +++++++++++
 tb/tb_ahb_slave_mux.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_mux.sv
// AHB-Lite response multiplexer with built-in default slave for unmapped addresses.
// Optional error counter output is enabled by defining AHB_SLAVE_MUX_ERR_CNT_EN.
module ahb_slave_mux #(
  parameter int SEL_WIDTH  = 2,
  parameter int DATA_WIDTH = 32
) (
  input  logic                            HCLK,
  input  logic                            HRESETn,
  input  logic [SEL_WIDTH-1:0]            HSEL,
  input  logic [1:0]                      HTRANS,
  input  logic [SEL_WIDTH*DATA_WIDTH-1:0] HRDATA_S,
  input  logic [SEL_WIDTH-1:0]            HREADYOUT_S,
  input  logic [SEL_WIDTH-1:0]            HRESP_S,
  output logic [DATA_WIDTH-1:0]           HRDATA,
  output logic                            HREADY,
  output logic                            HRESP
`ifdef AHB_SLAVE_MUX_ERR_CNT_EN
  ,
  output logic [15:0]                     err_cnt
`endif
);

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_t;

  ds_state_t                 state_reg;
  logic [SEL_WIDTH-1:0]      dsel_reg;
  logic [SEL_WIDTH-1:0]      hsel_first;
  logic [SEL_WIDTH:0]        hsel_seen;
  logic                      hsel_any;
  logic                      unmapped_active;
  logic [DATA_WIDTH-1:0]     rdata_masked [SEL_WIDTH];
  logic [DATA_WIDTH-1:0]     rdata_or;
  logic                      unused_htrans0;

  // Priority chain: a select bit survives only if no lower index is also set.
  assign hsel_seen[0] = 1'b0;
  genvar gi;
  generate
    for (gi = 0; gi < SEL_WIDTH; gi++) begin : g_slave
      assign hsel_first[gi]    = HSEL[gi] & ~hsel_seen[gi];
      assign hsel_seen[gi+1]   = hsel_seen[gi] | HSEL[gi];
      assign rdata_masked[gi]  = {DATA_WIDTH{dsel_reg[gi]}} & HRDATA_S[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  assign hsel_any        = hsel_seen[SEL_WIDTH];
  assign unmapped_active = HREADY & ~hsel_any & HTRANS[1];
  assign unused_htrans0  = HTRANS[0];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_reg <= DS_IDLE;
      dsel_reg  <= '0;
    end else begin
      if (HREADY) begin
        dsel_reg <= hsel_first;
      end
      case (state_reg)
        DS_IDLE: if (unmapped_active) state_reg <= DS_ERR1;
        DS_ERR1: state_reg <= DS_ERR2;
        DS_ERR2: state_reg <= unmapped_active ? DS_ERR1 : DS_IDLE;
        default: state_reg <= DS_IDLE;
      endcase
    end
  end

  always_comb begin
    rdata_or = '0;
    for (int i = 0; i < SEL_WIDTH; i++) begin
      rdata_or = rdata_or | rdata_masked[i];
    end
  end

  // Default slave owns the bus during its error cycles; otherwise route by dsel.
  always_comb begin
    HRDATA = '0;
    HREADY = 1'b1;
    HRESP  = 1'b0;
    case (state_reg)
      DS_ERR1: begin
        HREADY = 1'b0;
        HRESP  = 1'b1;
      end
      DS_ERR2: begin
        HREADY = 1'b1;
        HRESP  = 1'b1;
      end
      default: begin
        if (|dsel_reg) begin
          HRDATA = rdata_or;
          HREADY = |(dsel_reg & HREADYOUT_S);
          HRESP  = |(dsel_reg & HRESP_S);
        end
      end
    endcase
  end

`ifdef AHB_SLAVE_MUX_ERR_CNT_EN
  logic [15:0] err_cnt_reg;

  // Entry into DS_ERR1 coincides with unmapped_active, since HREADY is low while in DS_ERR1.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      err_cnt_reg <= '0;
    end else if (unmapped_active && (err_cnt_reg != 16'hFFFF)) begin
      err_cnt_reg <= err_cnt_reg + 16'd1;
    end
  end

  assign err_cnt = err_cnt_reg;
`endif

endmodule

// File: tb/tb_ahb_slave_mux.sv
// Directed self-checking bench for ahb_slave_mux (2 slaves, 32-bit data).
// Define AHB_SLAVE_MUX_ERR_CNT_EN for both files to also check err_cnt.
module tb_ahb_slave_mux;

  logic        HCLK;
  logic        HRESETn;
  logic [1:0]  HSEL;
  logic [1:0]  HTRANS;
  logic [63:0] HRDATA_S;
  logic [1:0]  HREADYOUT_S;
  logic [1:0]  HRESP_S;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;
`ifdef AHB_SLAVE_MUX_ERR_CNT_EN
  logic [15:0] err_cnt;
`endif

  int total_cnt;
  int bad_cnt;

  ahb_slave_mux #(
    .SEL_WIDTH  (2),
    .DATA_WIDTH (32)
  ) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .HSEL        (HSEL),
    .HTRANS      (HTRANS),
    .HRDATA_S    (HRDATA_S),
    .HREADYOUT_S (HREADYOUT_S),
    .HRESP_S     (HRESP_S),
    .HRDATA      (HRDATA),
    .HREADY      (HREADY),
    .HRESP       (HRESP)
`ifdef AHB_SLAVE_MUX_ERR_CNT_EN
    ,
    .err_cnt     (err_cnt)
`endif
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge, where new inputs are driven.
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  // Let combinational outputs settle before sampling, well before the falling edge.
  task automatic settle();
    #2;
  endtask

  task automatic chk_bus(input string tag, input logic rdy, input logic rsp, input logic [31:0] dat);
    settle();
    chk({tag, ".hready"}, {31'd0, HREADY}, {31'd0, rdy});
    chk({tag, ".hresp"},  {31'd0, HRESP},  {31'd0, rsp});
    chk({tag, ".hrdata"}, HRDATA, dat);
  endtask

  task automatic chk_errs(input string tag, input int exp);
`ifdef AHB_SLAVE_MUX_ERR_CNT_EN
    chk({tag, ".err_cnt"}, {16'd0, err_cnt}, exp[31:0]);
`else
    if (exp < 0) $display("note %s", tag);
`endif
  endtask

  initial begin
    total_cnt   = 0;
    bad_cnt     = 0;
    HRESETn     = 1'b0;
    HSEL        = 2'b01;
    HTRANS      = 2'b10;
    HRDATA_S    = {32'hCAFEF00D, 32'h12345678};
    HREADYOUT_S = 2'b11;
    HRESP_S     = 2'b00;

    $display("txn reset_initial");
    tick();
    chk_bus("reset", 1'b1, 1'b0, 32'h0);
    chk_errs("reset", 0);
    tick();
    HRESETn = 1'b1;
    HSEL    = 2'b00;
    HTRANS  = 2'b00;

    // Slave 0 read with two wait states
    $display("txn s0_read_2wait");
    tick();
    HSEL = 2'b01; HTRANS = 2'b10;
    chk_bus("s0w.addr", 1'b1, 1'b0, 32'h0);
    tick();
    HSEL = 2'b00; HTRANS = 2'b00;
    HREADYOUT_S = 2'b10; HRDATA_S[31:0] = 32'hDEADBEEF;
    settle();
    chk("s0w.wait1", {31'd0, HREADY}, 32'd0);
    tick();
    settle();
    chk("s0w.wait2", {31'd0, HREADY}, 32'd0);
    tick();
    HREADYOUT_S = 2'b11;
    chk_bus("s0w.data", 1'b1, 1'b0, 32'hDEADBEEF);

    // Pipelined slave0 -> slave1, no bubble
    $display("txn pipelined_s0_s1");
    tick();
    HSEL = 2'b01; HTRANS = 2'b10;
    tick();
    HSEL = 2'b10; HTRANS = 2'b10;
    HRDATA_S = {32'h0BADC0DE, 32'h11111111};
    chk_bus("pipe.d0", 1'b1, 1'b0, 32'h11111111);
    tick();
    HSEL = 2'b00; HTRANS = 2'b00;
    HRDATA_S = {32'h22222222, 32'h33333333};
    chk_bus("pipe.d1", 1'b1, 1'b0, 32'h22222222);

    // Unmapped NONSEQ: two-cycle ERROR
    $display("txn unmapped_nonseq");
    tick();
    HSEL = 2'b00; HTRANS = 2'b10;
    chk_bus("unm.addr", 1'b1, 1'b0, 32'h0);
    tick();
    HTRANS = 2'b00;
    chk_bus("unm.err1", 1'b0, 1'b1, 32'h0);
    tick();
    chk_bus("unm.err2", 1'b1, 1'b1, 32'h0);
    tick();
    chk_bus("unm.after", 1'b1, 1'b0, 32'h0);
    chk_errs("unm", 1);

    // Unmapped IDLE and BUSY complete with OKAY
    $display("txn unmapped_idle_busy");
    HTRANS = 2'b01;
    tick();
    HTRANS = 2'b00;
    chk_bus("busy.data", 1'b1, 1'b0, 32'h0);
    tick();
    chk_bus("idle.data", 1'b1, 1'b0, 32'h0);
    chk_errs("idle", 1);

    // Back-to-back unmapped NONSEQs
    $display("txn unmapped_back_to_back");
    HTRANS = 2'b10;
    tick();
    chk_bus("b2b.e1a", 1'b0, 1'b1, 32'h0);
    tick();
    chk_bus("b2b.e2a", 1'b1, 1'b1, 32'h0);
    tick();
    HTRANS = 2'b00;
    chk_bus("b2b.e1b", 1'b0, 1'b1, 32'h0);
    tick();
    chk_bus("b2b.e2b", 1'b1, 1'b1, 32'h0);
    tick();
    chk_bus("b2b.after", 1'b1, 1'b0, 32'h0);
    chk_errs("b2b", 3);

    // Multi-hot select: slave 0 wins, slave 1 ignored
    $display("txn multi_hot");
    HSEL = 2'b11; HTRANS = 2'b10;
    tick();
    HSEL = 2'b00; HTRANS = 2'b00;
    HRDATA_S = {32'h5A5A5A5A, 32'hAAAA5555};
    HREADYOUT_S = 2'b01; HRESP_S = 2'b10;
    chk_bus("mhot.data", 1'b1, 1'b0, 32'hAAAA5555);
    tick();
    HREADYOUT_S = 2'b11; HRESP_S = 2'b00;

    // Slave 1 ERROR passes through unchanged
    $display("txn s1_error_passthru");
    HSEL = 2'b10; HTRANS = 2'b10;
    tick();
    HSEL = 2'b00; HTRANS = 2'b00;
    HREADYOUT_S = 2'b01; HRESP_S = 2'b10;
    chk_bus("s1err.c1", 1'b0, 1'b1, 32'h5A5A5A5A);
    tick();
    HREADYOUT_S = 2'b11;
    chk_bus("s1err.c2", 1'b1, 1'b1, 32'h5A5A5A5A);
    tick();
    HRESP_S = 2'b00;
    chk_bus("s1err.after", 1'b1, 1'b0, 32'h0);
    chk_errs("s1err", 3);

    // Reset asserted mid-wait
    $display("txn reset_mid_wait");
    HSEL = 2'b01; HTRANS = 2'b10;
    tick();
    HSEL = 2'b00; HTRANS = 2'b00;
    HREADYOUT_S = 2'b10;
    settle();
    chk("rstw.pre", {31'd0, HREADY}, 32'd0);
    HRESETn = 1'b0;
    #1;
    chk_bus("rstw.post", 1'b1, 1'b0, 32'h0);
    chk_errs("rstw", 0);
    tick();
    HREADYOUT_S = 2'b11;
    HRESETn = 1'b1;

    // Reset asserted mid-error
    $display("txn reset_mid_error");
    HTRANS = 2'b10;
    tick();
    HTRANS = 2'b00;
    chk_bus("rste.err1", 1'b0, 1'b1, 32'h0);
    chk_errs("rste.err1", 1);
    HRESETn = 1'b0;
    #1;
    chk_bus("rste.post", 1'b1, 1'b0, 32'h0);
    chk_errs("rste.post", 0);
    tick();
    HRESETn = 1'b1;

    // First post-reset capture works normally
    $display("txn post_reset_capture");
    tick();
    HSEL = 2'b10; HTRANS = 2'b10;
    tick();
    HSEL = 2'b00; HTRANS = 2'b00;
    HRDATA_S = {32'h600DF00D, 32'h77777777};
    chk_bus("prc.data", 1'b1, 1'b0, 32'h600DF00D);
    tick();
    chk_bus("prc.idle", 1'b1, 1'b0, 32'h0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
